// File: rtl/modn_cascade_counter.sv
// modn_cascade_counter: DIGITS cascaded modulo-MODULUS digits that count up
// or down, with enable, parallel load, and carry computed across all digits
// in the same cycle.
//
// Optional feature: define MODN_COUNTER_SAT_EN to make the counter saturate
// at all-max or all-zero instead of wrapping.
//
// Parameters:
//   MODULUS  count range per digit, 0..MODULUS-1 (2..256)
//   DIGITS   number of cascaded digits (1..8)
//   DW       bits per digit, derived as $clog2(MODULUS)
//
// Ports:
//   clk       clock; all state changes on posedge
//   clear     synchronous active-high reset
//   en        count enable
//   up        direction: 1 = increment, 0 = decrement
//   load      synchronous parallel load; has priority over en
//   load_val  load value; digit k is [k*DW +: DW]
//   count     current value, same packing as load_val
//   tc        combinational terminal count; chains into a downstream en
//   wrap      registered one-cycle pulse after a whole-counter wrap
//             (a blocked step when saturating)
//   load_err  registered one-cycle pulse after a load with a bad digit
module modn_cascade_counter #(
  parameter int MODULUS = 10,
  parameter int DIGITS = 2,
  localparam int DW = $clog2(MODULUS)
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 en,
  input  logic                 up,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_val,
  output logic [DIGITS*DW-1:0] count,
  output logic                 tc,
  output logic                 wrap,
  output logic                 load_err
);

  // One extra bit so MODULUS still fits when it is exactly 2^DW.
  localparam logic [DW:0] MOD_W = (DW+1)'(MODULUS);
  localparam logic [DW-1:0] MAX_D = DW'(MODULUS - 1);
  localparam logic [DW:0] ONE_W = (DW+1)'(1);

  logic [DIGITS*DW-1:0] stepped;
  logic [DIGITS*DW-1:0] loaded;
  logic [DIGITS*DW-1:0] nxt;
  logic                 run;
  logic                 all_end;
  logic                 bad;
  logic                 wrap_d;
  logic                 err_d;
  logic [DW-1:0]        d;
  logic [DW:0]          inc;
  logic [DW-1:0]        f;

  // run is high at digit k when every lower digit sits at its end value
  // for the current direction, so digit k receives the step.
  // After the loop it reports whether the whole counter is at its end.
  always_comb begin
    stepped = count;
    run = 1'b1;
    d = '0;
    inc = '0;
    for (int k = 0; k < DIGITS; k++) begin
      d = count[k*DW +: DW];
      inc = {1'b0, d} + ONE_W;
      if (run) begin
        if (up)
          stepped[k*DW +: DW] = (inc == MOD_W) ? '0 : inc[DW-1:0];
        else
          stepped[k*DW +: DW] = (d == '0) ? MAX_D : d - DW'(1);
      end
      run = run & (up ? (d == MAX_D) : (d == '0));
    end
    all_end = run;
  end

  // Illegal load digits become 0; the other digits still load.
  always_comb begin
    loaded = '0;
    bad = 1'b0;
    f = '0;
    for (int k = 0; k < DIGITS; k++) begin
      f = load_val[k*DW +: DW];
      if ({1'b0, f} >= MOD_W)
        bad = 1'b1;
      else
        loaded[k*DW +: DW] = f;
    end
  end

  always_comb begin
    nxt = count;
    wrap_d = 1'b0;
    err_d = 1'b0;
    if (load) begin
      nxt = loaded;
      err_d = bad;
    end else if (en) begin
      wrap_d = all_end;
`ifdef MODN_COUNTER_SAT_EN
      if (!all_end)
        nxt = stepped;
`else
      nxt = stepped;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
      wrap <= 1'b0;
      load_err <= 1'b0;
    end else begin
      count <= nxt;
      wrap <= wrap_d;
      load_err <= err_d;
    end
  end

  assign tc = en & ~load & ~clear & all_end;

endmodule
